// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage execute unit: op codes, FSM states and
// op-class decode helpers used by both the datapath and its testbench.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

  // Operand a is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_div_serial.sv
// Restoring radix-2 serial divider: loads on start, runs XLEN iterations, then
// holds sign-corrected quotient/remainder with done=1 until the next start/kill.
module alu_div_serial #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  quo_reg, rem_reg, dvs_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg, done_reg, neg_q_reg, neg_r_reg;

  logic            a_neg, b_neg, ge;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted;

  assign a_neg = is_signed & dividend[XLEN-1];
  assign b_neg = is_signed & divisor[XLEN-1];
  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  // Shift in the next dividend bit; subtract only when the divisor fits.
  assign shifted = {rem_reg, quo_reg[XLEN-1]};
  assign ge      = shifted >= {1'b0, dvs_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (kill) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (start) begin
      quo_reg   <= a_mag;
      rem_reg   <= '0;
      dvs_reg   <= b_mag;
      cnt_reg   <= CNT_W'(XLEN);
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
    end else if (busy_reg) begin
      rem_reg <= ge ? (shifted[XLEN-1:0] - dvs_reg) : shifted[XLEN-1:0];
      quo_reg <= {quo_reg[XLEN-2:0], ge};
      cnt_reg <= cnt_reg - 1'b1;
      if (cnt_reg == CNT_W'(1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
  assign remainder = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage execute unit: single-cycle base ops, fixed-latency multiply and a
// serial divider behind a valid/ready handshake with one op in flight.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);
  localparam int MCW = $clog2(MUL_LAT + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_reg, state_next;
  logic [4:0]      op_reg;
  logic [XLEN-1:0] a_reg, b_reg, result_reg, result_next, base_res, mul_sel, div_fix;
  logic [MCW-1:0]  mul_cnt_reg;
  logic            zero_reg, load_result, accept;

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign accept    = in_valid && in_ready && !flush;

  // Base-op datapath
  always_comb begin
    base_res = '0;
    case (op_reg)
      OP_ADD:  base_res = a_reg + b_reg;
      OP_SUB:  base_res = a_reg - b_reg;
      OP_AND:  base_res = a_reg & b_reg;
      OP_OR:   base_res = a_reg | b_reg;
      OP_XOR:  base_res = a_reg ^ b_reg;
      OP_SLL:  base_res = a_reg << b_reg[SHW-1:0];
      OP_SRL:  base_res = a_reg >> b_reg[SHW-1:0];
      OP_SRA:  base_res = $signed(a_reg) >>> b_reg[SHW-1:0];
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a_reg) < $signed(b_reg)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a_reg < b_reg};
      default: base_res = '0;
    endcase
  end

  // Multiplier: sign/zero-extend to 2*XLEN so one signed product covers all four ops.
  logic signed [2*XLEN-1:0] a_ext, b_ext;
  logic [2*XLEN-1:0]        prod_comb, mul_final;

  assign a_ext     = {{XLEN{is_signed_a(op_reg) & a_reg[XLEN-1]}}, a_reg};
  assign b_ext     = {{XLEN{is_signed_b(op_reg) & b_reg[XLEN-1]}}, b_reg};
  assign prod_comb = a_ext * b_ext;

  generate
    if (MUL_LAT == 1) begin : g_mul_direct
      assign mul_final = prod_comb;
    end else begin : g_mul_pipe
      logic [2*XLEN-1:0] pipe_reg [MUL_LAT-1];
      for (genvar gi = 0; gi < MUL_LAT - 1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk or posedge rst) begin
            if (rst) pipe_reg[gi] <= '0;
            else     pipe_reg[gi] <= prod_comb;
          end
        end else begin : g_rest
          always_ff @(posedge clk or posedge rst) begin
            if (rst) pipe_reg[gi] <= '0;
            else     pipe_reg[gi] <= pipe_reg[gi-1];
          end
        end
      end
      assign mul_final = pipe_reg[MUL_LAT-2];
    end
  endgenerate

  assign mul_sel = (op_reg == OP_MUL) ? mul_final[XLEN-1:0] : mul_final[2*XLEN-1:XLEN];

  // Divider and its special-case fixups
  logic            div_busy, div_done;
  logic [XLEN-1:0] div_q, div_r;

  alu_div_serial #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div(op)),
    .kill      (flush),
    .is_signed (is_signed_a(op)),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    div_fix = op_reg[1] ? div_r : div_q;
    if (b_reg == '0) begin
      div_fix = op_reg[1] ? a_reg : '1;
    end else if (is_signed_a(op_reg) && (a_reg == MIN_INT) && (b_reg == '1)) begin
      div_fix = op_reg[1] ? '0 : MIN_INT;
    end
  end

  always_comb begin
    state_next  = state_reg;
    load_result = 1'b0;
    result_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul(op))      state_next = ST_MUL;
          else if (is_div(op)) state_next = ST_DIV;
          else                 state_next = ST_BASE;
        end
      end
      ST_BASE: begin
        state_next  = ST_DONE;
        load_result = 1'b1;
        result_next = base_res;
      end
      ST_MUL: begin
        if (mul_cnt_reg == MCW'(MUL_LAT - 1)) begin
          state_next  = ST_DONE;
          load_result = 1'b1;
          result_next = mul_sel;
        end
      end
      ST_DIV: begin
        if (div_done && !div_busy) begin
          state_next  = ST_DONE;
          load_result = 1'b1;
          result_next = div_fix;
        end
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next  = ST_IDLE;
      load_result = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      mul_cnt_reg <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg      <= op;
        a_reg       <= a;
        b_reg       <= b;
        mul_cnt_reg <= '0;
      end else if (state_reg == ST_MUL) begin
        mul_cnt_reg <= mul_cnt_reg + 1'b1;
      end
      if (load_result) begin
        result_reg <= result_next;
        zero_reg   <= (result_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: hand-computed vectors, latency, hold, flush
// and mid-operation reset, each checked with an immediate assertion.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic            in_ready, out_valid, zero;
  logic [4:0]      op;
  logic [XLEN-1:0] a, b, result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, measure accept-to-out_valid latency, check result.
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input string tag);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    $display("[TB] %s op=%h a=%h b=%h result=%h zero=%0d lat=%0d", tag, o, x, y, result, zero, n);
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " result"}, result, exp);
    check({tag, " zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
    @(posedge clk);
    #1 check({tag, " back to idle"}, {31'b0, in_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    #1;
    check("reset in_ready", {31'b0, in_ready}, 32'h1);
    check("reset out_valid", {31'b0, out_valid}, 32'h0);
    check("reset result", result, 32'h0);
    check("reset zero", {31'b0, zero}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Base ops
    run_op(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, "ADD wrap");
    run_op(OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1, "SRA");
    run_op(OP_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1, "SUB");
    run_op(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, "SLT");
    run_op(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, "SLTU");
    run_op(OP_XOR,  32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF005A5A, 1, "XOR");
    run_op(5'h1F,   32'h12345678, 32'h00000001, 32'h00000000, 1, "illegal");

    // Multiply
    run_op(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, "MULH");
    run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "MULHU");
    run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, "MULHSU");
    run_op(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT, "MUL");

    // Divide
    run_op(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, XLEN + 1, "DIV -7/2");
    run_op(OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, XLEN + 1, "REM -7%2");
    run_op(OP_DIVU, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, XLEN + 1, "DIVU by 0");
    run_op(OP_REMU, 32'h00000007, 32'h00000000, 32'h00000007, XLEN + 1, "REMU by 0");
    run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, XLEN + 1, "DIV ovf");
    run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, XLEN + 1, "REM ovf");
    run_op(OP_DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, XLEN + 1, "DIVU 100/7");
    run_op(OP_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, XLEN + 1, "REM 7%-2");

    // Hold in DONE with out_ready low; in_valid pulses must be ignored
    out_ready = 1'b0;
    @(negedge clk);
    op = OP_ADD; a = 32'd10; b = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    $display("[TB] hold ADD result=%h lat=%0d", result, n);
    check("hold latency", 32'(n), 32'h1);
    check("hold result", result, 32'd30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = OP_SUB; a = 32'(i); b = 32'd99; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("hold stable result", result, 32'd30);
      check("hold in_ready", {31'b0, in_ready}, 32'h0);
      check("hold out_valid", {31'b0, out_valid}, 32'h1);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release in_ready", {31'b0, in_ready}, 32'h1);
    check("release out_valid", {31'b0, out_valid}, 32'h0);
    run_op(OP_OR, 32'h00F0, 32'h0F00, 32'h0FF0, 1, "OR after hold");

    // Flush during a divide
    @(negedge clk);
    op = OP_DIV; a = 32'd100; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush in_ready", {31'b0, in_ready}, 32'h1);
    check("flush out_valid", {31'b0, out_valid}, 32'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    $display("[TB] flush DIV out_valid_seen=%0d", seen);
    check("flush no out_valid", 32'(seen), 32'h0);

    // Async reset during a multiply
    @(negedge clk);
    op = OP_MUL; a = 32'd6; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst in_ready", {31'b0, in_ready}, 32'h1);
    check("midrst out_valid", {31'b0, out_valid}, 32'h0);
    check("midrst result", result, 32'h0);
    check("midrst zero", {31'b0, zero}, 32'h1);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    $display("[TB] reset MUL out_valid_seen=%0d", seen);
    check("midrst no out_valid", 32'(seen), 32'h0);
    run_op(OP_ADD, 32'd2, 32'd3, 32'd5, 1, "ADD after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
